// File: rtl/ram_access_arbiter.sv
// -----------------------------------------------------------------------------
// ram_access_arbiter
//
// Shares one single-port synchronous RAM between two requesters: the decoder
// (port 0) and the filter (port 1). Ownership is granted per port with a
// burst limit. Port 0 wins ties from idle. An owner gives up the RAM after
// MAX_BURST accesses when the other port is waiting, so neither port starves.
// The owner's access is forwarded combinationally to the RAM. Read data is
// returned through a tag pipeline, so each read completes to the port that
// issued it, even if ownership has changed since.
//
// Parameters
//   DATA_WIDTH     RAM word width
//   ADDRESS_WIDTH  RAM address width
//   MAX_BURST      accesses an owner may issue while the other port waits (>=1)
//   READ_LATENCY   RAM read latency in cycles (>=1)
//
// Ports
//   clk                  clock, rising edge
//   rst                  asynchronous reset, active low
//   req0/req1            access request, port 0 / port 1
//   we0/we1              1 = write, 0 = read
//   address0/address1    access address
//   wdata0/wdata1        write data
//   gnt0/gnt1            port owns the RAM (from state register)
//   rdata0/rdata1        read data (always ram_data_input), qualified by rvalid
//   rvalid0/rvalid1      one-cycle pulse per completed read
//   busy                 arbiter not idle
//   ram_CE/ram_WE        RAM chip enable / write enable
//   ram_address          RAM address
//   ram_data_output      write data to RAM
//   ram_data_input       read data from RAM
// -----------------------------------------------------------------------------
module ram_access_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 17,
  parameter int MAX_BURST     = 16,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] address0,
  input  logic [ADDRESS_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic                     busy,
  output logic                     ram_CE,
  output logic                     ram_WE,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_data_output,
  input  logic [DATA_WIDTH-1:0]    ram_data_input
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_count_inc;

  logic w_acc0;
  logic w_acc1;
  logic w_read;

  logic [READ_LATENCY-1:0] r_pipe_valid;
  logic [READ_LATENCY-1:0] r_pipe_port;
  logic [READ_LATENCY-1:0] w_pipe_valid_in;
  logic [READ_LATENCY-1:0] w_pipe_port_in;

  // An access is accepted only when the owner requests.
  // Requests from the non-owner are never forwarded.
  assign w_acc0 = (r_state == OWN0) && req0;
  assign w_acc1 = (r_state == OWN1) && req1;
  assign w_read = (w_acc0 && !we0) || (w_acc1 && !we1);

  // Count after this cycle's access. The count saturates at MAX_BURST, so a
  // competing request that arrives late still forces a handover.
  assign w_count_inc = (r_count == BURST_MAX) ? BURST_MAX : r_count + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Ownership state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      IDLE: begin
        if (req0) begin
          w_state_next = OWN0;
        end else if (req1) begin
          w_state_next = OWN1;
        end
      end
      OWN0: begin
        if (!req0) begin
          w_state_next = req1 ? OWN1 : IDLE;
        end else if ((w_count_inc == BURST_MAX) && req1) begin
          // The current access still completes; port 1 owns the RAM next cycle.
          w_state_next = OWN1;
        end else begin
          w_count_next = w_count_inc;
        end
      end
      OWN1: begin
        if (!req1) begin
          w_state_next = req0 ? OWN0 : IDLE;
        end else if ((w_count_inc == BURST_MAX) && req0) begin
          w_state_next = OWN0;
        end else begin
          w_count_next = w_count_inc;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // Each ownership starts with a fresh burst budget.
    if (w_state_next != r_state) begin
      w_count_next = '0;
    end
  end

  assign gnt0 = (r_state == OWN0);
  assign gnt1 = (r_state == OWN1);
  assign busy = (r_state != IDLE);

  // ---------------------------------------------------------------------------
  // RAM drive: forwarded combinationally from the owning port
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_CE          = 1'b0;
    ram_WE          = 1'b0;
    ram_address     = '0;
    ram_data_output = '0;
    if (w_acc0) begin
      ram_CE          = 1'b1;
      ram_WE          = we0;
      ram_address     = address0;
      ram_data_output = wdata0;
    end else if (w_acc1) begin
      ram_CE          = 1'b1;
      ram_WE          = we1;
      ram_address     = address1;
      ram_data_output = wdata1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return pipeline: each stage holds {valid, port} for one read in
  // flight. A read issued in cycle N reaches the last stage in N+READ_LATENCY.
  // The RAM data arrives in that same cycle.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign w_pipe_valid_in[gi] = w_read;
        assign w_pipe_port_in[gi]  = w_acc1;
      end else begin : g_body
        assign w_pipe_valid_in[gi] = r_pipe_valid[gi-1];
        assign w_pipe_port_in[gi]  = r_pipe_port[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe_valid <= '0;
      r_pipe_port  <= '0;
    end else begin
      r_pipe_valid <= w_pipe_valid_in;
      r_pipe_port  <= w_pipe_port_in;
    end
  end

  assign rvalid0 = r_pipe_valid[READ_LATENCY-1] && !r_pipe_port[READ_LATENCY-1];
  assign rvalid1 = r_pipe_valid[READ_LATENCY-1] &&  r_pipe_port[READ_LATENCY-1];

  // Both ports see the RAM output directly; rvalid selects the consumer.
  assign rdata0 = ram_data_input;
  assign rdata1 = ram_data_input;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for ram_access_arbiter.
// The bench drives two request queues, and a simple RAM model answers the RAM
// port. A reference model at the transaction level checks every cycle. It
// tracks the owner, the burst length and the reads in flight, and it keeps a
// shadow copy of the RAM contents.
// -----------------------------------------------------------------------------
module tb_ram_access_arbiter;

  localparam int DW  = 8;
  localparam int AW  = 17;
  localparam int MB  = 16;
  localparam int RL  = 1;

  logic          clk;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] address0, address1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_CE, ram_WE;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_output;
  logic [DW-1:0] ram_data_input;

  ram_access_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .MAX_BURST    (MB),
    .READ_LATENCY (RL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req0           (req0),
    .req1           (req1),
    .we0            (we0),
    .we1            (we1),
    .address0       (address0),
    .address1       (address1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .rdata0         (rdata0),
    .rdata1         (rdata1),
    .rvalid0        (rvalid0),
    .rvalid1        (rvalid1),
    .busy           (busy),
    .ram_CE         (ram_CE),
    .ram_WE         (ram_WE),
    .ram_address    (ram_address),
    .ram_data_output(ram_data_output),
    .ram_data_input (ram_data_input)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // RAM model (environment, read latency 1)
  // ---------------------------------------------------------------------------
  logic          ram_init;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ram_rd;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 8'hAB : 8'(i);
      ram_rd <= '0;
    end else if (ram_CE) begin
      if (ram_WE) mem[ram_address[7:0]] <= ram_data_output;
      else        ram_rd <= mem[ram_address[7:0]];
    end
  end
  assign ram_data_input = ram_rd;

  // ---------------------------------------------------------------------------
  // Requesters: each port plays a queue of items. A request is held until
  // the port sees gnt; each granted cycle consumes one item.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            idle;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  item_t it0, it1;
  logic  acc0_seen, acc1_seen;

  function automatic item_t rand_item(input int idle_pct);
    item_t it;
    it.idle = ($urandom_range(0, 99) < idle_pct);
    it.we   = 1'($urandom_range(0, 1));
    it.addr = AW'($urandom_range(0, 31));
    it.data = DW'($urandom);
    return it;
  endfunction

  function automatic item_t mk_item(input bit we, input int addr, input int data);
    item_t it;
    it.idle = 1'b0;
    it.we   = we;
    it.addr = AW'(addr);
    it.data = DW'(data);
    return it;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!req0 || acc0_seen) begin
      if (q0.size() > 0) begin
        it0 = q0.pop_front();
        req0 = !it0.idle; we0 = it0.we; address0 = it0.addr; wdata0 = it0.data;
      end else begin
        req0 = 1'b0;
      end
    end
    if (!req1 || acc1_seen) begin
      if (q1.size() > 0) begin
        it1 = q1.pop_front();
        req1 = !it1.idle; we1 = it1.we; address1 = it1.addr; wdata1 = it1.data;
      end else begin
        req1 = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model.
  // owner: 0 = none, 1 = port 0, 2 = port 1.
  // burst: accesses by the current owner, capped at MB.
  // ---------------------------------------------------------------------------
  typedef struct {
    int            due;
    bit            port;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pend[$];
  logic [DW-1:0] shadow [0:255];
  int            m_owner = 0;
  int            m_burst = 0;
  int            rv0_cnt = 0;
  int            rv1_cnt = 0;

  always @(negedge clk) begin
    if (rvalid0) rv0_cnt++;
    if (rvalid1) rv1_cnt++;
  end

  always @(negedge clk) begin
    bit            e_acc0, e_acc1, e_rv0, e_rv1, mine, other;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rd;
    bit            e_we;
    logic [DW-1:0] e_wd;
    pend_t         p;
    if (ram_init) begin
      for (int i = 0; i < 256; i++) shadow[i] = (i == 16) ? 8'hAB : 8'(i);
    end
    check_val("rdata0_follow", 32'(rdata0), 32'(ram_data_input));
    check_val("rdata1_follow", 32'(rdata1), 32'(ram_data_input));
    if (!rst) begin
      m_owner = 0; m_burst = 0; pend.delete();
      acc0_seen = 1'b0; acc1_seen = 1'b0;
      check_val("rst_gnt0", 32'(gnt0), 0);
      check_val("rst_gnt1", 32'(gnt1), 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_ce", 32'(ram_CE), 0);
      check_val("rst_we", 32'(ram_WE), 0);
      check_val("rst_addr", 32'(ram_address), 0);
      check_val("rst_dout", 32'(ram_data_output), 0);
      check_val("rst_rvalid0", 32'(rvalid0), 0);
      check_val("rst_rvalid1", 32'(rvalid1), 0);
    end else begin
      e_acc0 = (m_owner == 1) && req0;
      e_acc1 = (m_owner == 2) && req1;
      e_addr = e_acc0 ? address0 : (e_acc1 ? address1 : '0);
      e_we   = e_acc0 ? we0 : (e_acc1 ? we1 : 1'b0);
      e_wd   = e_acc0 ? wdata0 : (e_acc1 ? wdata1 : '0);
      check_val("gnt0", 32'(gnt0), 32'(m_owner == 1));
      check_val("gnt1", 32'(gnt1), 32'(m_owner == 2));
      check_val("busy", 32'(busy), 32'(m_owner != 0));
      check_val("ram_ce", 32'(ram_CE), 32'(e_acc0 || e_acc1));
      check_val("ram_we", 32'(ram_WE), 32'(e_we));
      check_val("ram_addr", 32'(ram_address), 32'(e_addr));
      check_val("ram_dout", 32'(ram_data_output), 32'(e_wd));

      e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        if (p.port) e_rv1 = 1'b1; else e_rv0 = 1'b1;
        e_rd = p.data;
      end
      check_val("rvalid0", 32'(rvalid0), 32'(e_rv0));
      check_val("rvalid1", 32'(rvalid1), 32'(e_rv1));
      if (e_rv0) check_val("rdata0", 32'(rdata0), 32'(e_rd));
      if (e_rv1) check_val("rdata1", 32'(rdata1), 32'(e_rd));

      if (e_acc0 || e_acc1) begin
        if (e_we) begin
          shadow[e_addr[7:0]] = e_wd;
          $display("cycle %0d port%0d WR addr=%0h data=%0h", cyc, e_acc1, e_addr, e_wd);
        end else begin
          p.due = cyc + RL; p.port = e_acc1; p.data = shadow[e_addr[7:0]];
          pend.push_back(p);
          $display("cycle %0d port%0d RD addr=%0h expect=%0h", cyc, e_acc1, e_addr, p.data);
        end
      end

      acc0_seen = req0 && gnt0;
      acc1_seen = req1 && gnt1;

      // Ownership for the next cycle.
      if (m_owner == 0) begin
        if (req0)      m_owner = 1;
        else if (req1) m_owner = 2;
        m_burst = 0;
      end else begin
        mine  = (m_owner == 1) ? req0 : req1;
        other = (m_owner == 1) ? req1 : req0;
        if (!mine) begin
          m_owner = other ? 3 - m_owner : 0;
          m_burst = 0;
        end else begin
          m_burst = (m_burst + 1 > MB) ? MB : m_burst + 1;
          if (m_burst == MB && other) begin
            m_owner = 3 - m_owner;
            m_burst = 0;
          end
        end
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0 || req1) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) check_val("drain_timeout", 1, 0);
    repeat (RL + 2) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, s1, n, t;
    rst = 1'b0; ram_init = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    address0 = '0; address1 = '0; wdata0 = '0; wdata1 = '0;
    acc0_seen = 0; acc1_seen = 0;
    repeat (3) @(posedge clk);
    #2;
    ram_init = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single requester: port 1 reads addresses 0..3.
    s0 = rv0_cnt; s1 = rv1_cnt;
    for (int a = 0; a < 4; a++) q1.push_back(mk_item(1'b0, a, 0));
    wait_drain(100);
    check_val("single_rv1_cnt", 32'(rv1_cnt - s1), 4);
    check_val("single_rv0_cnt", 32'(rv0_cnt - s0), 0);

    // Both ports request together: port 0 gets exactly MB accesses first.
    for (int k = 0; k < 40; k++) begin
      q0.push_back(mk_item(1'b0, k % 32, 0));
      q1.push_back(mk_item(1'b0, (k + 5) % 32, 0));
    end
    n = 0; t = 0;
    @(negedge clk);
    while (!gnt1 && t < 100) begin
      if (gnt0 && req0) n++;
      @(negedge clk);
      t++;
    end
    check_val("burst0_len", 32'(n), 32'(MB));
    wait_drain(500);

    // Early release: port 0 stops after 3 accesses while port 1 waits.
    for (int k = 0; k < 3; k++)  q0.push_back(mk_item(1'b0, k, 0));
    for (int k = 0; k < 10; k++) q1.push_back(mk_item(1'b0, 20 + k, 0));
    wait_drain(200);

    // Read across handover: port 0's 16th access is a read of 0x10.
    s0 = rv0_cnt; s1 = rv1_cnt;
    for (int k = 0; k < MB - 1; k++) q0.push_back(mk_item(1'b0, k, 0));
    q0.push_back(mk_item(1'b0, 16'h10, 0));
    for (int k = 0; k < 4; k++) q1.push_back(mk_item(1'b0, 1 + k, 0));
    wait_drain(200);
    check_val("handover_rv0_cnt", 32'(rv0_cnt - s0), 32'(MB));
    check_val("handover_rv1_cnt", 32'(rv1_cnt - s1), 4);

    // Write then read from the other port.
    s0 = rv0_cnt; s1 = rv1_cnt;
    q0.push_back(mk_item(1'b1, 7, 8'h5A));
    wait_drain(100);
    q1.push_back(mk_item(1'b0, 7, 0));
    wait_drain(100);
    check_val("write_rv0_cnt", 32'(rv0_cnt - s0), 0);
    check_val("write_rv1_cnt", 32'(rv1_cnt - s1), 1);

    // Reset while port 0 has a read in flight.
    for (int k = 1; k <= 6; k++) q0.push_back(mk_item(1'b0, k, 0));
    repeat (3) @(posedge clk);
    #2;
    check_val("pre_rst_gnt0", 32'(gnt0), 1);
    check_val("pre_rst_ce", 32'(ram_CE), 1);
    rst = 1'b0;
    #1;
    check_val("async_gnt0", 32'(gnt0), 0);
    check_val("async_busy", 32'(busy), 0);
    check_val("async_ce", 32'(ram_CE), 0);
    check_val("async_rvalid0", 32'(rvalid0), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    wait_drain(200);

    // Randomized traffic: first dense on both ports, then port 1 sparse.
    for (int k = 0; k < 300; k++) begin
      q0.push_back(rand_item(20));
      q1.push_back(rand_item(20));
    end
    wait_drain(5000);
    for (int k = 0; k < 300; k++) begin
      q0.push_back(rand_item(10));
      q1.push_back(rand_item(70));
    end
    wait_drain(5000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Sequencing arbiter that shares one single-port synchronous RAM (image or histogram RAM) between two requesters: the decoder (port 0) and the filter (port 1). It grants ownership with a per-owner burst limit so the decoder keeps priority without starving the filter. It drives the RAM control, address and write data, and returns tagged read data to whichever requester issued the read. It replaces the combinational priority encoder in front of each shared RAM.

## Interface
- DATA_WIDTH, 8: RAM word width.
- ADDRESS_WIDTH, 17: RAM address width.
- MAX_BURST, 16: maximum accesses an owner may issue while the other port waits (≥1).
- READ_LATENCY, 1: RAM read latency in cycles (≥1).

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  access request from port 0 (decoder) / port 1 (filter).
- we0, we1  in  1  write (1) or read (0) for the requested access.
- address0, address1  in  ADDRESS_WIDTH  access address.
- wdata0, wdata1  in  DATA_WIDTH  write data.
- gnt0, gnt1  out  1  port currently owns the RAM; registered.
- rdata0, rdata1  out  DATA_WIDTH  read data; qualified by rvalid.
- rvalid0, rvalid1  out  1  read data valid; one-cycle pulse per read.
- busy  out  1  state ≠ IDLE.
- ram_CE, ram_WE  out  1  RAM chip enable / write enable.
- ram_address  out  ADDRESS_WIDTH  RAM address.
- ram_data_output  out  DATA_WIDTH  write data to RAM.
- ram_data_input  in  DATA_WIDTH  read data from RAM.

## Operation
- State machine: IDLE, OWN0, OWN1. gnt0 = (state==OWN0), gnt1 = (state==OWN1).
- Access issue: in OWNx with reqx=1, drive ram_CE=1, ram_WE=wex, ram_address=addressx, ram_data_output=wdatax (combinational from owner inputs). Otherwise ram_CE=0, ram_WE=0, ram_address=0, ram_data_output=0. A non-owner request is never forwarded.
- Requester rule: hold req, we, address and wdata stable until gnt is seen. Each cycle with gnt=1 and req=1 is exactly one accepted access.
- IDLE: if req0, go to OWN0. Else if req1, go to OWN1. Else stay. When both request, port 0 wins.
- OWNx: burst counter (width clog2(MAX_BURST)+1) increments on each accepted access.
  - If reqx=0: go to OWN(other) if the other port requests, else IDLE.
  - Else if this cycle's access makes count == MAX_BURST and the other port requests: go to OWN(other). The current access still completes.
  - Else stay. If count reaches MAX_BURST with no competing request, the count saturates and ownership continues.
- The counter clears on every state change.
- Handover has no dead cycle: OWN0 → OWN1 gives gnt1=1 the next cycle.
- Read return: a READ_LATENCY-deep shift register carries {valid, port id} for each accepted read (CE=1, WE=0).
  - At the tail, assert rvalid of the tagged port for one cycle.
  - rdata0 = rdata1 = ram_data_input at all times.
  - Writes produce no rvalid.
- Reads in flight complete to their issuing port even after ownership changes.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, counter=0, read pipeline cleared. All outputs go to 0: gnt0/1, rvalid0/1, busy, ram_CE, ram_WE, ram_address, ram_data_output. rdata follows ram_data_input.
- Reset mid-burst drops pending reads; no rvalid fires after reset.
- Request to grant: req asserted in cycle N from IDLE gives gnt in cycle N+1. The first access is issued in N+1.
- Read latency: access issued in cycle N gives rvalid in cycle N+READ_LATENCY, with the matching data.
- Throughput: one access per cycle, including across a handover.
- Fairness bound: while port 1 requests continuously, port 0 issues at most MAX_BURST consecutive accesses before port 1 is granted. The symmetric bound applies to port 1.
- MAX_BURST=1 yields strict alternation when both ports request continuously.

## Test plan
- Reset mid-read: rst low while OWN0 has a read in flight → all outputs 0 immediately; no rvalid after release; gnt0 rises 1 cycle after req0 reasserts.
- Single requester: req1=1, we1=0, addresses 0..3 for 4 cycles; RAM preloaded with data=address → gnt1 from cycle 1; rvalid1 in cycles 2..5 with rdata 0,1,2,3; rvalid0 never asserts.
- Simultaneous request from IDLE: req0=req1=1 → gnt0 first. With MAX_BURST=16, exactly 16 port-0 accesses occur, then gnt1 the next cycle, then 16 port-1 accesses, repeating.
- Early release: owner 0 drops req0 after 3 accesses while req1=1 → gnt1 asserts the next cycle, with no idle ram_CE=0 gap beyond the dropped cycle; the counter restarts at 0.
- Read across handover: port 0's last access is a read at address 0x10 (data 0xAB), followed by a switch to port 1 → rvalid0 with rdata 0xAB one cycle later while port 1 already drives the RAM; rvalid1 does not assert for that read.
- Writes: port 0 writes 0x5A at address 7, then port 1 reads address 7 → ram_WE=1 only in the write cycle; rvalid1 with rdata 0x5A; no rvalid for the write.
